// File: rtl/sample_accumulator.sv
`timescale 1ns/1ps
// sample_accumulator
// Front/back end for an external 16-bit adder. Each accepted sample is
// latched into an operand register and added to the running accumulator
// through the add_* ports. When a burst of NUM_SAMPLES samples is complete
// the total and a sticky overflow flag are published with a one-cycle strobe.
// The adder operands come straight from registers, so there is no
// combinational path from sample_data to the adder.
module sample_accumulator #(
  parameter int NUM_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_carry_in,
  input  logic [15:0] add_sum,
  input  logic        add_overflow,
  output logic        result_valid,
  output logic [15:0] result_data,
  output logic        result_overflow,
  output logic        busy
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,        state_d;
  logic [15:0]      acc_q,          acc_d;
  logic [CNT_W-1:0] count_q,        count_d;
  logic [15:0]      operand_q,      operand_d;
  logic             sticky_q,       sticky_d;
  logic             res_valid_q,    res_valid_d;
  logic [15:0]      res_data_q,     res_data_d;
  logic             res_ovf_q,      res_ovf_d;
  logic             ready_q,        ready_d;
  logic             busy_q,         busy_d;

  // Next-state and datapath update: clear aborts, otherwise the FSM steps.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    operand_d   = operand_q;
    sticky_d    = sticky_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;

    if (clear) begin
      // Abort: drop the partial burst; published results are left alone
      // and any sample offered this cycle is ignored.
      state_d   = ST_IDLE;
      acc_d     = 16'h0000;
      count_d   = CNT_ZERO;
      operand_d = 16'h0000;
      sticky_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            operand_d = sample_data;
            state_d   = ST_ADD;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_ADD: begin
          // add_sum is already truncated modulo 2^16; the carry-out only
          // feeds the sticky flag.
          acc_d    = add_sum;
          sticky_d = sticky_q | add_overflow;
          count_d  = count_q + CNT_ONE;
          if (count_d == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          res_data_d  = acc_q;
          res_ovf_d   = sticky_q;
          res_valid_d = 1'b1;
          acc_d       = 16'h0000;
          count_d     = CNT_ZERO;
          sticky_d    = 1'b0;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          acc_d     = 16'h0000;
          count_d   = CNT_ZERO;
          operand_d = 16'h0000;
          sticky_d  = 1'b0;
        end
      endcase
    end

    // Handshake and status flags are registered alongside the state so they
    // reflect the state the block will be in during the next cycle.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (count_d != CNT_ZERO) || (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= 16'h0000;
      count_q     <= CNT_ZERO;
      operand_q   <= 16'h0000;
      sticky_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      res_ovf_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      operand_q   <= operand_d;
      sticky_q    <= sticky_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign sample_ready    = ready_q;
  assign add_a           = operand_q;
  assign add_b           = acc_q;
  assign add_carry_in    = 1'b0;
  assign result_valid    = res_valid_q;
  assign result_data     = res_data_q;
  assign result_overflow = res_ovf_q;
  assign busy            = busy_q;

endmodule
